// File: rtl/wavegen_pkg.sv
// Shared definitions for the waveform synthesis chain: sample format,
// DAC frame geometry, output-stage FSM states and the DAC code conversion.
package wavegen_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int DAC_FRAME_BITS = 16;
    localparam int BITCNT_W       = $clog2(DAC_FRAME_BITS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [DAC_FRAME_BITS-1:0]  dac_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } ser_state_t;

    // Offset binary maps the most negative sample to code zero.
    function automatic dac_word_t to_dac_code(
        input sample_t s,
        input bit      offset_binary
    );
        dac_word_t w;
        w = dac_word_t'(s);
        if (offset_binary) begin
            w[DAC_FRAME_BITS-1] = ~w[DAC_FRAME_BITS-1];
        end
        return w;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered occupancy; read data is the head entry.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/dac_serializer.sv
// DAC output stage: buffers synthesis samples and shifts each one out as a
// 16-bit MSB-first frame on a chip-select / serial-clock / data bus.
module dac_serializer
    import wavegen_pkg::*;
#(
    parameter int CLKDIV        = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter bit OFFSET_BINARY = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SAMPLE_W-1:0]         sample,
    input  logic                        activein,
    output logic                        dac_csn,
    output logic                        dac_sclk,
    output logic                        dac_sdi,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int HALF_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [HALF_W-1:0]   HALF_LAST = HALF_W'(CLKDIV - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BITCNT_W-1:0] BIT_LAST  = BITCNT_W'(DAC_FRAME_BITS - 1);

    if (CLKDIV < 1) begin : g_bad_clkdiv
        $error("CLKDIV must be at least 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    ser_state_t          state_q, state_d;
    dac_word_t           shreg_q, shreg_d;
    logic [BITCNT_W-1:0] bit_q, bit_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                csn_q, csn_d;
    logic                sclk_q, sclk_d;
    logic                sdi_q, sdi_d;
    logic                ovf_q, ovf_d;

    logic [SAMPLE_W-1:0] fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    dac_word_t           pop_word;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (activein),
        .pop_i   (fifo_pop),
        .wdata_i (sample),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Pops only from IDLE, so a sample is never bypassed onto the bus.
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
    assign pop_word = to_dac_code(sample_t'(fifo_rdata), OFFSET_BINARY);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        half_d  = half_q;
        gap_d   = gap_q;
        csn_d   = csn_q;
        sclk_d  = sclk_q;
        sdi_d   = sdi_q;
        ovf_d   = ovf_q | (activein & fifo_full & ~fifo_pop);

        unique case (state_q)
            ST_IDLE: begin
                csn_d  = 1'b1;
                sclk_d = 1'b0;
                if (fifo_pop) begin
                    shreg_d = pop_word;
                    csn_d   = 1'b0;
                    sdi_d   = pop_word[DAC_FRAME_BITS-1];
                    bit_d   = '0;
                    half_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == BIT_LAST) begin
                        sclk_d  = 1'b0;
                        csn_d   = 1'b1;
                        sdi_d   = 1'b0;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        // Data moves only on the falling edge of sclk.
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + BITCNT_W'(1);
                        shreg_d = {shreg_q[DAC_FRAME_BITS-2:0], 1'b0};
                        sdi_d   = shreg_q[DAC_FRAME_BITS-2];
                    end
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                csn_d   = 1'b1;
                sclk_d  = 1'b0;
                sdi_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            half_q  <= '0;
            gap_q   <= '0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dac_csn  = csn_q;
    assign dac_sclk = sclk_q;
    assign dac_sdi  = sdi_q;
    assign overflow = ovf_q;
    assign busy     = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: two parameterisations share one stimulus stream
// and are compared every cycle against a frame-timing model.
module tb_dac_serializer;

    localparam int N     = 2;
    localparam int DEPTH = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] sample   = '0;
    logic        activein = 1'b0;

    logic       csn  [N];
    logic       sclk [N];
    logic       sdi  [N];
    logic       busy [N];
    logic       ovf  [N];
    logic [2:0] lvl  [N];

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_serializer #(
        .CLKDIV(2), .GAP_CYCLES(2), .FIFO_DEPTH(DEPTH), .OFFSET_BINARY(1'b1)
    ) dut0 (
        .clk(clk), .reset(reset), .sample(sample), .activein(activein),
        .dac_csn(csn[0]), .dac_sclk(sclk[0]), .dac_sdi(sdi[0]),
        .busy(busy[0]), .overflow(ovf[0]), .fifo_level(lvl[0])
    );

    dac_serializer #(
        .CLKDIV(1), .GAP_CYCLES(1), .FIFO_DEPTH(DEPTH), .OFFSET_BINARY(1'b0)
    ) dut1 (
        .clk(clk), .reset(reset), .sample(sample), .activein(activein),
        .dac_csn(csn[1]), .dac_sclk(sclk[1]), .dac_sdi(sdi[1]),
        .busy(busy[1]), .overflow(ovf[1]), .fifo_level(lvl[1])
    );

    function automatic int cdv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int gapv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic logic [15:0] codev(input int i, input logic [15:0] s);
        return (i == 0) ? (s ^ 16'h8000) : s;
    endfunction

    // Model: a queue of samples plus "cycles since frame start" per instance.
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    bit          m_act [N];
    int          m_e   [N];
    logic [15:0] m_cur [N];
    bit          m_ovf [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int          sz;
            bit          pop;
            logic [15:0] w;
            sz = (i == 0) ? mq0.size() : mq1.size();
            if (reset) begin
                if (i == 0) mq0.delete(); else mq1.delete();
                m_act[i] = 0;
                m_e[i]   = 0;
                m_ovf[i] = 0;
            end else begin
                pop = !m_act[i] && sz > 0;
                if (pop) begin
                    if (i == 0) w = mq0.pop_front(); else w = mq1.pop_front();
                    m_cur[i] = codev(i, w);
                    m_act[i] = 1;
                    m_e[i]   = 0;
                end else if (m_act[i]) begin
                    m_e[i]++;
                    if (m_e[i] == 32 * cdv(i) + gapv(i)) m_act[i] = 0;
                end
                if (activein) begin
                    if (sz < DEPTH || pop) begin
                        if (i == 0) mq0.push_back(sample);
                        else mq1.push_back(sample);
                    end else begin
                        m_ovf[i] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
                int sz;
                int e;
                bit xc, xs, xd, xb;
                sz = (i == 0) ? mq0.size() : mq1.size();
                e  = m_e[i];
                if (m_act[i] && e < 32 * cdv(i)) begin
                    xc = 0;
                    xs = ((e / cdv(i)) % 2) == 1;
                    xd = m_cur[i][15 - e / (2 * cdv(i))];
                end else begin
                    xc = 1;
                    xs = 0;
                    xd = 0;
                end
                xb = m_act[i] || sz > 0;
                nvec++;
                if (csn[i] !== xc || sclk[i] !== xs || sdi[i] !== xd ||
                    busy[i] !== xb || ovf[i] !== m_ovf[i] || lvl[i] !== 3'(sz)) begin
                    nerr++;
                    $display("FAIL model dut%0d cyc %0d: got csn=%b sclk=%b sdi=%b busy=%b ovf=%b lvl=%0d want %b %b %b %b %b %0d",
                             i, cyc, csn[i], sclk[i], sdi[i], busy[i], ovf[i], lvl[i],
                             xc, xs, xd, xb, m_ovf[i], sz);
                end
            end
        end
    end

    // Bus monitor: captures frames the way the DAC would see them.
    bit          p_csn      [N] = '{1, 1};
    bit          p_sclk     [N] = '{0, 0};
    int          rises      [N];
    int          lowc       [N];
    int          totrise    [N] = '{0, 0};
    int          first_rise [N];
    int          done_cnt   [N] = '{0, 0};
    logic [15:0] shw        [N];
    logic [15:0] last_w     [N];
    int          last_rises [N];
    int          last_low   [N];
    int          cap0[$];
    int          fall0[$];
    int          fall1[$];

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
                if (sclk[i] === 1'b1 && !p_sclk[i]) totrise[i]++;
                if (p_csn[i] && csn[i] === 1'b0) begin
                    rises[i]      = 0;
                    lowc[i]       = 0;
                    shw[i]        = '0;
                    first_rise[i] = -1;
                    if (i == 0) fall0.push_back(cyc); else fall1.push_back(cyc);
                end
                if (csn[i] === 1'b0) begin
                    lowc[i]++;
                    if (sclk[i] === 1'b1 && !p_sclk[i]) begin
                        rises[i]++;
                        shw[i] = {shw[i][14:0], sdi[i]};
                        if (first_rise[i] < 0) first_rise[i] = cyc;
                    end
                end
                if (!p_csn[i] && csn[i] === 1'b1) begin
                    done_cnt[i]++;
                    last_w[i]     = shw[i];
                    last_rises[i] = rises[i];
                    last_low[i]   = lowc[i];
                    if (i == 0) cap0.push_back(int'(shw[i]));
                end
                p_csn[i]  = (csn[i] !== 1'b0);
                p_sclk[i] = (sclk[i] === 1'b1);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] s);
        sample   = s;
        activein = 1'b1;
        step();
        activein = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target, input string nm);
        int n;
        n = 0;
        while (done_cnt[i] < target && n < 2000) begin
            step();
            n++;
        end
        if (done_cnt[i] < target) begin
            nvec++;
            nerr++;
            $display("FAIL %s: frame timeout got %0d frames want %0d", nm, done_cnt[i], target);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy[0] !== 1'b0 || busy[1] !== 1'b0) && n < 2000) begin
            step();
            n++;
        end
        step();
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: idle timeout got busy=%b%b want 00", nm, busy[0], busy[1]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int          ts, d0, d1, pe, r, tr, n;
        bit          ps;
        logic [15:0] sv [6];
        logic [15:0] bvals [4];
        logic [15:0] bexp  [4];
        bvals = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
        bexp  = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};

        reset = 1'b1;
        repeat (3) step();
        chk("rst_csn", csn[0], 1);
        chk("rst_sclk", sclk[0], 0);
        chk("rst_sdi", sdi[0], 0);
        chk("rst_lvl", lvl[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_ovf", ovf[0], 0);
        reset = 1'b0;
        step();

        d0 = done_cnt[0];
        d1 = done_cnt[1];
        sample   = 16'h1234;
        activein = 1'b1;
        step();
        ts       = cyc;
        activein = 1'b0;
        wait_done(0, d0 + 1, "single");
        wait_done(1, d1 + 1, "single_ob0");
        chk("single_word", last_w[0], 16'h9234);
        chk("single_rises", last_rises[0], 16);
        chk("single_low", last_low[0], 64);
        chk("lat_fall", fall0[fall0.size() - 1] - ts, 1);
        chk("lat_rise", first_rise[0] - ts, 3);
        chk("ob0_word", last_w[1], 16'h1234);
        chk("cd1_low", last_low[1], 32);
        chk("cd1_rises", last_rises[1], 16);
        wait_idle("single");

        for (int k = 0; k < 4; k++) begin
            d0 = done_cnt[0];
            d1 = done_cnt[1];
            pulse(bvals[k]);
            wait_done(0, d0 + 1, "bnd");
            wait_done(1, d1 + 1, "bnd_ob0");
            chk($sformatf("bnd_ob1_%0d", k), last_w[0], bexp[k]);
            chk($sformatf("bnd_ob0_%0d", k), last_w[1], bvals[k]);
            wait_idle("bnd");
        end

        d0 = done_cnt[0];
        cap0.delete();
        fall0.delete();
        for (int k = 0; k < 6; k++) begin
            sv[k]    = 16'($urandom);
            sample   = sv[k];
            activein = 1'b1;
            step();
            if (k == 4) begin
                chk("b2b_lvl_full", lvl[0], 4);
                chk("b2b_ovf_pre", ovf[0], 0);
            end
            if (k == 5) begin
                chk("b2b_ovf", ovf[0], 1);
                chk("b2b_lvl_peak", lvl[0], 4);
            end
        end
        activein = 1'b0;
        wait_done(0, d0 + 5, "b2b");
        wait_idle("b2b");
        chk("b2b_count", cap0.size(), 5);
        for (int k = 0; k < 5 && k < cap0.size(); k++)
            chk($sformatf("b2b_order%0d", k), cap0[k], sv[k] ^ 16'h8000);
        for (int k = 1; k < 5 && k < fall0.size(); k++)
            chk($sformatf("b2b_period%0d", k), fall0[k] - fall0[k - 1], 67);
        chk("b2b_ovf_sticky", ovf[0], 1);
        do_reset();

        fall0.delete();
        pulse(16'h0101);
        for (int k = 0; k < 4; k++) pulse(16'($urandom));
        step();
        chk("full_lvl", lvl[0], 4);
        pe = (fall0.size() > 0) ? fall0[0] + 67 : cyc + 62;
        n = 0;
        while (cyc < pe - 1 && n < 200) begin
            step();
            n++;
        end
        chk("full_pre_lvl", lvl[0], 4);
        chk("full_pre_busy", busy[0], 1);
        sample   = 16'h5A5A;
        activein = 1'b1;
        step();
        activein = 1'b0;
        chk("full_pop_lvl", lvl[0], 4);
        chk("full_pop_ovf", ovf[0], 0);
        chk("full_pop_csn", csn[0], 0);
        wait_idle("full");
        chk("full_ovf_end", ovf[0], 0);

        pulse(16'h1111);
        pulse(16'h2222);
        pulse(16'h3333);
        r  = 0;
        ps = 0;
        n  = 0;
        while (r < 8 && n < 400) begin
            step();
            if (sclk[0] === 1'b1 && !ps) r++;
            ps = (sclk[0] === 1'b1);
            n++;
        end
        chk("mid_rises", r, 8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_csn", csn[0], 1);
        chk("mid_sclk", sclk[0], 0);
        chk("mid_lvl", lvl[0], 0);
        chk("mid_busy", busy[0], 0);
        tr = totrise[0];
        repeat (20) step();
        chk("mid_no_rise", totrise[0] - tr, 0);
        d0 = done_cnt[0];
        pulse(16'hABCD);
        wait_done(0, d0 + 1, "post_rst");
        chk("post_word", last_w[0], 16'h2BCD);
        chk("post_rises", last_rises[0], 16);
        chk("post_low", last_low[0], 64);
        wait_idle("post_rst");

        fall1.delete();
        activein = 1'b1;
        for (int k = 0; k < 160; k++) begin
            sample = 16'($urandom);
            step();
        end
        activein = 1'b0;
        chk("cont_frames", fall1.size() >= 4, 1);
        for (int k = 1; k < 4 && k < fall1.size(); k++)
            chk($sformatf("cont_period%0d", k), fall1[k] - fall1[k - 1], 34);
        chk("cont_low", last_low[1], 32);
        do_reset();

        for (int k = 0; k < 4000; k++) begin
            sample   = 16'($urandom);
            activein = ($urandom_range(0, 99) < ((k / 500) % 2 == 0 ? 3 : 40));
            reset    = ($urandom_range(0, 1499) == 0);
            step();
        end
        activein = 1'b0;
        reset    = 1'b0;
        wait_idle("random");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
